// File: rtl/alu_pkg.sv
// Op codes shared with the ALU control decoder, plus execute-unit state and helpers.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1011;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// Bit-serial shifter: one position per enabled cycle; last_o flags the final step so the
// caller can capture data_o on that same edge. No backpressure; the caller gates shift_en_i.
module alu_serial_shifter
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic            shift_en_i,
  input  logic [3:0]      code_i,
  input  logic [XLEN-1:0] data_i,
  input  logic [SHW-1:0]  shamt_i,
  output logic [XLEN-1:0] data_o,
  output logic            last_o
);

  logic [XLEN-1:0] sh_q, sh_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [3:0]      code_q, code_d;

  // data_o is the value after this cycle's step, not the stored value.
  always_comb begin
    data_o = {sh_q[XLEN-1], sh_q[XLEN-1:1]};
    if (code_q == ALU_SLL) begin
      data_o = {sh_q[XLEN-2:0], 1'b0};
    end else if (code_q == ALU_SRL) begin
      data_o = {1'b0, sh_q[XLEN-1:1]};
    end
  end

  assign last_o = shift_en_i && (cnt_q == SHW'(1));

  always_comb begin
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    code_d = code_q;
    if (start_i) begin
      sh_d   = data_i;
      cnt_d  = shamt_i;
      code_d = code_i;
    end else if (shift_en_i) begin
      sh_d  = data_o;
      cnt_d = cnt_q - SHW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      code_q <= ALU_SLL;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      code_q <= code_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle execute unit: single-cycle logic/arith/compare, serial shifts (1+shamt cycles).
// Result is held until out_ready; in_ready follows out_ready in DONE for back-to-back issue.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] op_res;
  logic            op_ill;
  logic            accept;
  logic            sh_start;
  logic            sh_last;
  logic [XLEN-1:0] sh_data;
  logic [SHW-1:0]  shamt;

  assign shamt     = src_b[SHW-1:0];
  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = (result_q == '0);
  assign illegal   = illegal_q;

  // Shift codes pass src_a through here, which is exactly the shamt==0 result.
  always_comb begin
    op_res = '0;
    op_ill = 1'b0;
    case (alu_ctrl)
      ALU_AND:  op_res = src_a & src_b;
      ALU_OR:   op_res = src_a | src_b;
      ALU_ADD:  op_res = src_a + src_b;
      ALU_XOR:  op_res = src_a ^ src_b;
      ALU_SUB:  op_res = src_a - src_b;
      ALU_SLT:  op_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_SLTU: op_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      ALU_SLL, ALU_SRL, ALU_SRA: op_res = src_a;
      default:  op_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    sh_start  = 1'b0;
    case (state_q)
      ST_SHIFT: begin
        if (sh_last) begin
          result_d = sh_data;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: ;
    endcase
    if (accept) begin
      if (is_shift(alu_ctrl) && (shamt != '0)) begin
        sh_start  = 1'b1;
        illegal_d = 1'b0;
        state_d   = ST_SHIFT;
      end else begin
        result_d  = op_res;
        illegal_d = op_ill;
        state_d   = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  alu_serial_shifter #(
    .XLEN(XLEN),
    .SHW (SHW)
  ) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .start_i   (sh_start),
    .shift_en_i(state_q == ST_SHIFT),
    .code_i    (alu_ctrl),
    .data_i    (src_a),
    .shamt_i   (shamt),
    .data_o    (sh_data),
    .last_o    (sh_last)
  );

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vector table, handshake/reset sequences, random ops vs model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [3:0]  alu_ctrl = 4'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        in_ready, out_valid, zero, illegal;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_ctrl (alu_ctrl),
    .src_a    (src_a),
    .src_b    (src_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h", nm, act, exp);
    end
  endtask

  // Reference: plain operators on the architectural rules, latency 1 or 1+shamt.
  function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ill, output int lat);
    int sh;
    sh  = int'(b[4:0]);
    ill = 1'b0;
    lat = 1;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0011: r = a ^ b;
      4'b0110: r = a - b;
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1011: r = (a < b) ? 32'd1 : 32'd0;
      4'b1000: begin r = a << sh; lat = 1 + sh; end
      4'b1001: begin r = a >> sh; lat = 1 + sh; end
      4'b1010: begin r = $signed(a) >>> sh; lat = 1 + sh; end
      default: begin r = 32'd0; ill = 1'b1; end
    endcase
  endfunction

  // Called and returns right after a falling edge.
  task automatic run_op(input string nm, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] r, input logic ill,
                        input int lat);
    int n;
    int got_lat;
    int ir_low;
    out_ready = 1'b1;
    alu_ctrl  = c;
    src_a     = a;
    src_b     = b;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk({nm, "_accept"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    alu_ctrl = 4'($urandom);
    src_a    = $urandom;
    src_b    = $urandom;
    got_lat = 1;
    ir_low  = 0;
    while (!out_valid && got_lat < 40) begin
      if (!in_ready) ir_low++;
      @(negedge clk);
      got_lat++;
    end
    chk({nm, "_latency"}, 32'(got_lat), 32'(lat));
    chk({nm, "_result"}, result, r);
    chk({nm, "_zero"}, 32'(zero), 32'(r == 32'd0));
    chk({nm, "_illegal"}, 32'(illegal), 32'(ill));
    if (lat > 1) chk({nm, "_busy_in_ready_low"}, 32'(ir_low), 32'(lat - 1));
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0]  rc;
    logic [31:0] ra, rb, rr;
    logic        ri;
    int          rl;
    int          seen;

    tbl[0]  = '{4'b0010, 32'd5,        32'd7,        32'd12,       1'b0, 1};
    tbl[1]  = '{4'b0110, 32'd9,        32'd9,        32'd0,        1'b0, 1};
    tbl[2]  = '{4'b0111, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1};
    tbl[3]  = '{4'b1011, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1};
    tbl[4]  = '{4'b1010, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 5};
    tbl[5]  = '{4'b1010, 32'h80000000, 32'd0,        32'h80000000, 1'b0, 1};
    tbl[6]  = '{4'b1111, 32'h12345678, 32'h1,        32'd0,        1'b1, 1};
    tbl[7]  = '{4'b0000, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 1'b0, 1};
    tbl[8]  = '{4'b1000, 32'd1,        32'd31,       32'h80000000, 1'b0, 32};
    tbl[9]  = '{4'b1001, 32'h80000000, 32'h0000003F, 32'd1,        1'b0, 32};
    tbl[10] = '{4'b0011, 32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5, 1'b0, 1};
    tbl[11] = '{4'b0100, 32'd3,        32'd3,        32'd0,        1'b1, 1};
    tbl[12] = '{4'b0010, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1};
    tbl[13] = '{4'b1001, 32'hF0000000, 32'd3,        32'h1E000000, 1'b0, 4};

    repeat (2) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_zero", 32'(zero), 32'd1);
    chk("reset_illegal", 32'(illegal), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 14; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].code, tbl[i].a, tbl[i].b,
             tbl[i].res, tbl[i].ill, tbl[i].lat);
    end

    // Backpressure then back-to-back accept on the releasing cycle.
    drain();
    out_ready = 1'b0;
    alu_ctrl  = 4'b0010;
    src_a     = 32'd3;
    src_b     = 32'd4;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_first_valid", 32'(out_valid), 32'd1);
    chk("bp_first_result", result, 32'd7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_result", i), result, 32'd7);
      chk($sformatf("bp_hold%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp_hold%0d_in_ready", i), 32'(in_ready), 32'd0);
    end
    alu_ctrl  = 4'b0001;
    src_a     = 32'h000000F0;
    src_b     = 32'h0000000F;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_valid", 32'(out_valid), 32'd1);
    chk("b2b_result", result, 32'h000000FF);

    // Reset in the middle of a long shift.
    run_op("pre_reset_add", 4'b0010, 32'd1, 32'd1, 32'd2, 1'b0, 1);
    alu_ctrl = 4'b1000;
    src_a    = 32'd1;
    src_b    = 32'd20;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_shift_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_reset_out_valid", 32'(out_valid), 32'd0);
    chk("mid_reset_result", result, 32'd0);
    chk("mid_reset_zero", 32'(zero), 32'd1);
    chk("mid_reset_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("after_reset_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    chk("after_reset_no_valid", 32'(seen), 32'd0);
    run_op("post_reset_add", 4'b0010, 32'd100, 32'd23, 32'd123, 1'b0, 1);

    // Random operations against the reference model.
    for (int i = 0; i < 300; i++) begin
      rc = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      model(rc, ra, rb, rr, ri, rl);
      run_op($sformatf("rand%0d_op%0h", i, rc), rc, ra, rb, rr, ri, rl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
